// File: rtl/row_serializer.sv
// ============================================================================
// Module   : row_serializer
// Purpose  : Buffers whole rows in a small FIFO and re-emits them one element
//            per cycle with first/last framing. ROW_SER_IDX_EN adds out_idx.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module row_serializer #(
  parameter int DATA_W  = 16,
  parameter int ROW_LEN = 3,
  parameter int DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_row [0:ROW_LEN-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
`ifdef ROW_SER_IDX_EN
  output logic              out_last,
  output logic [$clog2(ROW_LEN)-1:0] out_idx
`else
  output logic              out_last
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(ROW_LEN);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  elem_cnt_q, elem_cnt_d;
  logic [DATA_W-1:0] mem_q [0:DEPTH-1][0:ROW_LEN-1];

  logic push;
  logic pop_elem;
  logic row_done;
  logic elem_last;

  // Handshake readiness comes only from registered occupancy.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign elem_last = (elem_cnt_q == IDX_W'(ROW_LEN - 1));
  assign out_first = (elem_cnt_q == '0);
  assign out_last  = elem_last;
  assign out_data  = mem_q[rd_ptr_q][elem_cnt_q];

`ifdef ROW_SER_IDX_EN
  assign out_idx = elem_cnt_q;
`endif

  assign push     = in_valid && in_ready;
  assign pop_elem = out_valid && out_ready;
  assign row_done = pop_elem && elem_last;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    elem_cnt_d = elem_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop_elem) begin
      elem_cnt_d = elem_last ? '0 : elem_cnt_q + 1'b1;
    end

    if (row_done) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Simultaneous push and row completion leave occupancy unchanged.
    case ({push, row_done})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      elem_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      elem_cnt_q <= elem_cnt_d;
    end
  end

  // Row storage is not reset; out_valid gates its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int e = 0; e < ROW_LEN; e++) begin
        mem_q[wr_ptr_q][e] <= in_row[e];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_row_serializer.sv
// ============================================================================
// Module   : tb_row_serializer
// Purpose  : Directed self-checking bench for row_serializer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_row_serializer;

  localparam int DATA_W  = 16;
  localparam int ROW_LEN = 3;
  localparam int DEPTH   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_row [0:ROW_LEN-1];
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_first;
  logic              out_last;
`ifdef ROW_SER_IDX_EN
  logic [$clog2(ROW_LEN)-1:0] out_idx;
`endif

  int n_cmp = 0;
  int n_err = 0;

  row_serializer #(
    .DATA_W (DATA_W),
    .ROW_LEN(ROW_LEN),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_first(out_first),
`ifdef ROW_SER_IDX_EN
    .out_last (out_last),
    .out_idx  (out_idx)
`else
    .out_last (out_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_row(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    in_row[0] = a;
    in_row[1] = b;
    in_row[2] = c;
  endtask

  // Checks valid element with given data and framing.
  task automatic chk_el(input string tag, input logic [15:0] d, input logic f, input logic l);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".data"},  out_data,  d);
    chk({tag, ".first"}, out_first, f);
    chk({tag, ".last"},  out_last,  l);
  endtask

  initial begin
    int pushed;
    int row;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_row(16'h0, 16'h0, 16'h0);

    // Reset state
    tick();
    tick();
    chk("rst.in_ready",  in_ready,  1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_first", out_first, 1'b1);
    chk("rst.out_last",  out_last,  1'b0);
    rst_n = 1'b1;
    tick();

    // Single row, one element per cycle
    set_row(16'h0001, 16'h0002, 16'h0003);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_el("single.e0", 16'h0001, 1'b1, 1'b0);
    tick();
    chk_el("single.e1", 16'h0002, 1'b0, 1'b0);
    tick();
    chk_el("single.e2", 16'h0003, 1'b0, 1'b1);
    tick();
    chk("single.empty", out_valid, 1'b0);

    // Three rows pushed with output blocked; full FIFO rejects the third
    out_ready = 1'b0;
    set_row(16'h0011, 16'h0012, 16'h0013);
    in_valid = 1'b1;
    chk("fill.rdy0", in_ready, 1'b1);
    tick();
    set_row(16'h0021, 16'h0022, 16'h0023);
    chk("fill.rdy1", in_ready, 1'b1);
    tick();
    set_row(16'h0031, 16'h0032, 16'h0033);
    chk("fill.full", in_ready, 1'b0);
    tick();
    chk("fill.full_hold", in_ready, 1'b0);
    out_ready = 1'b1;
    chk_el("fill.a0", 16'h0011, 1'b1, 1'b0);
    tick();
    chk_el("fill.a1", 16'h0012, 1'b0, 1'b0);
    chk("fill.full_a1", in_ready, 1'b0);
    tick();
    chk_el("fill.a2", 16'h0013, 1'b0, 1'b1);
    chk("fill.full_a2", in_ready, 1'b0);
    tick();
    // Row A completed while full: third row was refused, accepted now
    chk("fill.rdy_after", in_ready, 1'b1);
    chk_el("fill.b0", 16'h0021, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_el("fill.b1", 16'h0022, 1'b0, 1'b0);
    tick();
    chk_el("fill.b2", 16'h0023, 1'b0, 1'b1);
    tick();
    chk_el("fill.c0", 16'h0031, 1'b1, 1'b0);
    tick();
    chk_el("fill.c1", 16'h0032, 1'b0, 1'b0);
    tick();
    chk_el("fill.c2", 16'h0033, 1'b0, 1'b1);
    tick();
    chk("fill.empty", out_valid, 1'b0);
    chk("fill.rdy_end", in_ready, 1'b1);

    // Stalls hold the current element
    out_ready = 1'b0;
    set_row(16'hAAAA, 16'h5555, 16'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_el("stall.e0", 16'hAAAA, 1'b1, 1'b0);
    tick();
    chk_el("stall.e0h", 16'hAAAA, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_el("stall.e1", 16'h5555, 1'b0, 1'b0);
    tick();
    chk_el("stall.e1h", 16'h5555, 1'b0, 1'b0);
    tick();
    chk_el("stall.e1h2", 16'h5555, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_el("stall.e2", 16'hFFFF, 1'b0, 1'b1);
    tick();
    chk_el("stall.e2h", 16'hFFFF, 1'b0, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("stall.empty", out_valid, 1'b0);

    // Reset mid-row with a second row buffered
    out_ready = 1'b0;
    set_row(16'h0041, 16'h0042, 16'h0043);
    in_valid = 1'b1;
    tick();
    set_row(16'h0051, 16'h0052, 16'h0053);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_el("mrst.e1", 16'h0042, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", out_valid, 1'b0);
    chk("mrst.in_ready",  in_ready,  1'b1);
    chk("mrst.out_first", out_first, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst.still_empty", out_valid, 1'b0);
    set_row(16'h0010, 16'h0020, 16'h0030);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_el("mrst.n0", 16'h0010, 1'b1, 1'b0);
    tick();
    chk_el("mrst.n1", 16'h0020, 1'b0, 1'b0);
    tick();
    chk_el("mrst.n2", 16'h0030, 1'b0, 1'b1);
    tick();
    chk("mrst.empty", out_valid, 1'b0);

    // Continuous stream of 4 rows across pointer wrap
    pushed    = 0;
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      set_row(16'h0100 * r[15:0], 16'h0100 * r[15:0] + 16'd1, 16'h0100 * r[15:0] + 16'd2);
      in_valid = 1'b1;
      tick();
      pushed++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      row = i / 3;
      chk_el($sformatf("strm.%0d", i), 16'h0100 * row[15:0] + 16'(i % 3),
             (i % 3) == 0, (i % 3) == 2);
`ifdef ROW_SER_IDX_EN
      chk($sformatf("strm.idx%0d", i), out_idx, i % 3);
`endif
      if (pushed < 4 && in_ready) begin
        set_row(16'h0100 * pushed[15:0], 16'h0100 * pushed[15:0] + 16'd1,
                16'h0100 * pushed[15:0] + 16'd2);
        in_valid = 1'b1;
        tick();
        pushed++;
      end else begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b0;
    end
    chk("strm.empty", out_valid, 1'b0);
    chk("strm.pushed", pushed, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
